// File: rtl/tl_ul_scratchpad_responder.sv
// TL-UL manager: decodes A-channel requests against a word-addressed scratchpad
// and returns D-channel responses in acceptance order through a small circular buffer.
module tl_ul_scratchpad_responder #(
  parameter logic [29:0] BASE_ADDR   = 30'h0,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned SOURCE_W    = 3,
  parameter int unsigned RESP_DEPTH  = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [1:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [29:0]         a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [1:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_sink,
  output logic                d_denied,
  output logic [31:0]         d_data,
  output logic                d_corrupt
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(RESP_DEPTH);
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  typedef struct packed {
    logic [2:0]          opcode;
    logic [1:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic [31:0]         data;
  } resp_t;

  logic [31:0]   mem [DEPTH_WORDS];
  resp_t         buffer [RESP_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic        a_fire, d_fire;
  logic [31:0] offset;
  logic [AW-1:0] index;
  logic        is_get, is_put, opcode_ok, in_range, aligned, mask_ok, denied;
  logic [3:0]  lane_mask;
  resp_t       resp;
  logic        unused_bits;

  assign a_ready = count != CW'(RESP_DEPTH);
  assign d_valid = count != '0;
  assign a_fire  = a_valid & a_ready & ~reset;
  assign d_fire  = d_valid & d_ready;

  // Addresses below the base wrap to a huge offset, so one compare covers both bounds.
  assign offset   = {2'b00, a_address} - {2'b00, BASE_ADDR};
  assign in_range = offset < SPAN;
  assign index    = offset[AW+1:2];

  always_comb begin
    is_get    = a_opcode == 3'd4;
    is_put    = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    opcode_ok = is_get | is_put;
    case (a_size)
      2'd0: begin aligned = 1'b1;                  lane_mask = 4'b0001 << a_address[1:0]; end
      2'd1: begin aligned = ~a_address[0];         lane_mask = 4'b0011 << a_address[1:0]; end
      2'd2: begin aligned = a_address[1:0] == '0;  lane_mask = 4'hF;                      end
      default: begin aligned = 1'b0;               lane_mask = '0;                        end
    endcase
    if (a_opcode == 3'd1) mask_ok = (a_mask & ~lane_mask) == '0;
    else                  mask_ok = a_mask == lane_mask;
    denied      = ~(opcode_ok & aligned & in_range & mask_ok);
    resp.opcode = {2'b00, is_get};
    resp.size   = a_size;
    resp.source = a_source;
    resp.denied = denied;
    resp.data   = (is_get & ~denied) ? mem[index] : '0;
  end

  always_ff @(posedge clock) begin
    if (a_fire && is_put && !denied) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (a_mask[b]) mem[index][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < RESP_DEPTH; i++) buffer[PW'(i)] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (a_fire) begin
        buffer[wr_ptr] <= resp;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (d_fire) rd_ptr <= rd_ptr + PW'(1);
      case ({a_fire, d_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign d_opcode  = buffer[rd_ptr].opcode;
  assign d_param   = '0;
  assign d_size    = buffer[rd_ptr].size;
  assign d_source  = buffer[rd_ptr].source;
  assign d_sink    = 1'b0;
  assign d_denied  = buffer[rd_ptr].denied;
  assign d_data    = buffer[rd_ptr].data;
  assign d_corrupt = buffer[rd_ptr].denied & (buffer[rd_ptr].opcode == 3'd1);

  assign unused_bits = ^{a_param, offset[31:AW+2], offset[1:0]};
endmodule

// File: tb/tb_tl_ul_scratchpad_responder.sv
// Bench for tl_ul_scratchpad_responder: directed protocol steps plus random traffic,
// every cycle compared against a queue-and-array model of the responder.
module tb_tl_ul_scratchpad_responder;
  localparam logic [29:0] BASE  = 30'h400;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned SW    = 3;
  localparam int unsigned RD    = 2;

  logic          clock = 1'b0;
  logic          reset, a_valid, a_ready, d_valid, d_ready;
  logic [2:0]    a_opcode, a_param, d_opcode;
  logic [1:0]    a_size, d_param, d_size;
  logic [SW-1:0] a_source, d_source;
  logic [29:0]   a_address;
  logic [3:0]    a_mask;
  logic [31:0]   a_data, d_data;
  logic          d_sink, d_denied, d_corrupt;
  logic [63:0]   d_head;

  tl_ul_scratchpad_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .SOURCE_W(SW), .RESP_DEPTH(RD)
  ) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt)
  );

  always #5 clock = ~clock;

  assign d_head = {19'b0, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data};

  typedef struct {
    logic [2:0]    op;
    logic [1:0]    size;
    logic [SW-1:0] src;
    logic          den;
    logic [31:0]   data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [DEPTH];
  int          checks = 0;
  int          failures = 0;
  bit          chk_en = 1'b0;
  bit          accepted;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Response for the beat currently on the A channel, derived from the protocol rules.
  task automatic predict(output exp_t e);
    int unsigned addr, bytes, lanes;
    logic [3:0]  expm;
    logic [7:0]  idx;
    bit          den;
    addr  = 32'(a_address);
    bytes = 32'd1 << a_size;
    den   = !(a_opcode inside {3'd0, 3'd1, 3'd4});
    if (a_size == 2'd3) den = 1'b1;
    if (addr % bytes != 0) den = 1'b1;
    if (addr < 32'(BASE) || addr >= 32'(BASE) + DEPTH * 4) den = 1'b1;
    lanes = ((32'd1 << bytes) - 1) << (addr % 4);
    expm  = lanes[3:0];
    if ((a_opcode == 3'd0 || a_opcode == 3'd4) && a_mask != expm) den = 1'b1;
    if (a_opcode == 3'd1 && (a_mask & ~expm) != 4'd0) den = 1'b1;
    idx    = 8'((addr - 32'(BASE)) / 4);
    e.op   = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
    e.size = a_size;
    e.src  = a_source;
    e.den  = den;
    e.data = '0;
    if (!den && a_opcode == 3'd4) e.data = ref_mem[idx];
    if (!den && a_opcode != 3'd4) begin
      for (int b = 0; b < 4; b++) if (a_mask[b]) ref_mem[idx][8*b +: 8] = a_data[8*b +: 8];
    end
  endtask

  // Called just after a falling edge with inputs settled; checks, advances the model, runs one clock.
  task automatic tick();
    exp_t e;
    bit   fire_a, fire_d;
    if (chk_en) begin
      chk("a_ready", 64'(a_ready), 64'(q.size() != RD));
      chk("d_valid", 64'(d_valid), 64'(q.size() != 0));
      if (q.size() != 0)
        chk("d_head", d_head, {19'b0, q[0].op, 2'b00, q[0].size, q[0].src, 1'b0, q[0].den,
                               q[0].den && q[0].op == 3'd1, q[0].data});
    end
    fire_d   = !reset && d_ready && q.size() != 0;
    fire_a   = !reset && a_valid && q.size() != RD;
    accepted = fire_a;
    if (reset) q.delete();
    else begin
      if (fire_d) void'(q.pop_front());
      if (fire_a) begin
        predict(e);
        q.push_back(e);
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic req(input logic [2:0] op, input logic [1:0] sz, input logic [29:0] addr,
                     input logic [3:0] mask, input logic [31:0] data, input logic [SW-1:0] src,
                     output int n_ticks);
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_address = addr;
    a_mask = mask; a_data = data; a_source = src;
    n_ticks = 0;
    for (int n = 0; n < 20; n++) begin
      if (n > 2) d_ready = 1'b1;
      tick();
      n_ticks = n + 1;
      if (accepted) break;
    end
    chk("accept_bound", 64'(accepted), 64'(1));
    a_valid = 1'b0;
  endtask

  task automatic drain();
    d_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int n;
    int unsigned bytes, off, w, addr, m;
    logic [2:0] op;
    logic [1:0] sz;

    reset = 1'b1; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
    a_address = BASE; a_mask = '0; a_data = '0; d_ready = 1'b0;
    @(negedge clock);
    tick();
    tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_a_ready", 64'(a_ready), 64'(1));
    chk("rst_d_valid", 64'(d_valid), 64'(0));
    chk("rst_d_fields", d_head, 64'(0));

    // PutFull then Get at BASE+0x10
    d_ready = 1'b1;
    req(3'd0, 2'd2, BASE + 30'h10, 4'hF, 32'hDEADBEEF, 3'd5, n);
    chk("putfull_ack", 64'({d_valid, d_opcode, d_denied, d_source}), 64'({1'b1, 3'd0, 1'b0, 3'd5}));
    req(3'd4, 2'd2, BASE + 30'h10, 4'hF, 32'h0, 3'd2, n);
    chk("get_deadbeef", 64'({d_opcode, d_data}), 64'({3'd1, 32'hDEADBEEF}));
    req(3'd1, 2'd2, BASE + 30'h10, 4'b0010, 32'h0000AA00, 3'd3, n);
    req(3'd4, 2'd2, BASE + 30'h10, 4'hF, 32'h0, 3'd4, n);
    chk("get_partial", 64'(d_data), 64'(32'hDEADAAEF));

    // Three Gets with D stalled: third held until the buffer drains
    drain();
    d_ready = 1'b0;
    req(3'd4, 2'd2, BASE + 30'h10, 4'hF, 32'h0, 3'd1, n);
    req(3'd4, 2'd2, BASE + 30'h10, 4'hF, 32'h0, 3'd2, n);
    a_valid = 1'b1; a_source = 3'd3;
    tick();
    chk("third_held", 64'(accepted), 64'(0));
    chk("full_a_ready", 64'(a_ready), 64'(0));
    chk("head_src_first", 64'(d_source), 64'(1));
    d_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (accepted) break;
    end
    chk("third_accepted", 64'(accepted), 64'(1));
    a_valid = 1'b0;

    // Denied requests
    drain();
    req(3'd4, 2'd2, BASE + 30'(DEPTH * 4), 4'hF, 32'h0, 3'd6, n);
    chk("oob_get", 64'({d_opcode, d_denied, d_corrupt, d_data}), 64'({3'd1, 1'b1, 1'b1, 32'h0}));
    req(3'd4, 2'd2, BASE + 30'h2, 4'hF, 32'h0, 3'd7, n);
    chk("misaligned_get", 64'(d_denied), 64'(1));
    req(3'd3, 2'd2, BASE + 30'h10, 4'hF, 32'h12, 3'd0, n);
    chk("bad_opcode", 64'({d_opcode, d_denied, d_corrupt}), 64'({3'd0, 1'b1, 1'b0}));
    req(3'd4, 2'd2, BASE - 30'h4, 4'hF, 32'h0, 3'd1, n);

    // Streaming Puts: one accept per cycle; fills words 0..31 for random traffic
    drain();
    for (int i = 0; i < 32; i++) begin
      req(3'd0, 2'd2, BASE + 30'(i * 4), 4'hF, $urandom, SW'(i), n);
      chk("stream_1cyc", 64'(n), 64'(1));
    end

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      d_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2: op = 3'd0;
        3, 4:    op = 3'd1;
        9:       op = ($urandom_range(0, 1) != 0) ? 3'd2 : 3'd5;
        default: op = 3'd4;
      endcase
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) sz = 2'd3;
      bytes = 32'd1 << sz;
      w     = $urandom_range(0, 31);
      off   = ($urandom_range(0, 3) >> sz) << sz;
      addr  = 32'(BASE) + w * 4 + off;
      if ($urandom_range(0, 15) == 0) addr = 32'(BASE) + DEPTH * 4 + w * 4;
      if ($urandom_range(0, 15) == 0) addr = addr + 1;
      m = ((32'd1 << bytes) - 1) << (addr % 4);
      if (op == 3'd1) m = m & $urandom;
      if ($urandom_range(0, 11) == 0) m = $urandom;
      req(op, sz, 30'(addr), 4'(m), $urandom, SW'($urandom_range(0, 7)), n);
      if ($urandom_range(0, 4) == 0) tick();
    end

    // Reset with two responses pending; a beat during reset must not write
    drain();
    d_ready = 1'b0;
    req(3'd0, 2'd2, BASE + 30'd160, 4'hF, 32'h12345678, 3'd1, n);
    req(3'd0, 2'd2, BASE + 30'd164, 4'hF, 32'h0BADF00D, 3'd2, n);
    reset = 1'b1;
    a_valid = 1'b1; a_opcode = 3'd0; a_size = 2'd2; a_address = BASE + 30'd160;
    a_mask = 4'hF; a_data = 32'hCAFEF00D;
    tick();
    chk("rst_mid_d_valid", 64'(d_valid), 64'(0));
    chk("rst_mid_a_ready", 64'(a_ready), 64'(1));
    tick();
    reset = 1'b0;
    a_valid = 1'b0;
    chk("post_rst_d_valid", 64'(d_valid), 64'(0));
    chk("post_rst_a_ready", 64'(a_ready), 64'(1));
    d_ready = 1'b1;
    req(3'd4, 2'd2, BASE + 30'd160, 4'hF, 32'h0, 3'd3, n);
    chk("mem_persist", 64'(d_data), 64'(32'h12345678));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
